// File: rtl/tc_io_pkg.sv
// Shared defaults and types for the GPIO pad bank.
// Optional open-drain support is enabled by TC_IO_OPEN_DRAIN_EN.
package tc_io_pkg;
  localparam int TC_IO_NUM_PAD_DEF = 8;
  localparam int TC_IO_SYNC_DEF    = 2;
  localparam int TC_IO_DEB_W_DEF   = 8;

  typedef logic [TC_IO_DEB_W_DEF-1:0] tc_io_deb_cnt_t;

  typedef struct packed {
    logic rise;
    logic fall;
  } tc_io_edge_t;
endpackage

// File: rtl/tc_io_gpio_if.sv
// Register-block side of the GPIO bank.
// TC_IO_OPEN_DRAIN_EN adds the od_i open-drain select.
interface tc_io_gpio_if #(
  parameter int NUM_PAD = 8,
  parameter int DEB_W   = 8
);
`ifdef TC_IO_OPEN_DRAIN_EN
  logic [NUM_PAD-1:0] od_i;
`endif
  logic [NUM_PAD-1:0] out_i;
  logic [NUM_PAD-1:0] oe_i;
  logic [NUM_PAD-1:0] deb_en_i;
  logic [DEB_W-1:0]   deb_thr_i;
  logic [NUM_PAD-1:0] ie_rise_i;
  logic [NUM_PAD-1:0] ie_fall_i;
  logic [NUM_PAD-1:0] pend_clr_i;
  logic [NUM_PAD-1:0] in_o;
  logic [NUM_PAD-1:0] rise_o;
  logic [NUM_PAD-1:0] fall_o;
  logic [NUM_PAD-1:0] pend_o;
  logic               irq_o;

  modport master (
`ifdef TC_IO_OPEN_DRAIN_EN
    output od_i,
`endif
    output out_i, oe_i, deb_en_i, deb_thr_i,
    output ie_rise_i, ie_fall_i, pend_clr_i,
    input  in_o, rise_o, fall_o, pend_o, irq_o
  );

  modport slave (
`ifdef TC_IO_OPEN_DRAIN_EN
    input  od_i,
`endif
    input  out_i, oe_i, deb_en_i, deb_thr_i,
    input  ie_rise_i, ie_fall_i, pend_clr_i,
    output in_o, rise_o, fall_o, pend_o, irq_o
  );
endinterface

// File: rtl/tc_io_gpio_chan.sv
// One GPIO channel: pad cell, synchroniser, debounce, edges, pending bit.
// TC_IO_OPEN_DRAIN_EN adds the od_i open-drain select.
module tc_io_gpio_chan
  import tc_io_pkg::*;
#(
  parameter int SYNC_STAGES = TC_IO_SYNC_DEF,
  parameter int DEB_W       = TC_IO_DEB_W_DEF,
  parameter bit SCHMITT     = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  inout  wire              pad_io,
  input  logic             out_i,
  input  logic             oe_i,
`ifdef TC_IO_OPEN_DRAIN_EN
  input  logic             od_i,
`endif
  input  logic             deb_en_i,
  input  logic [DEB_W-1:0] deb_thr_i,
  input  logic             ie_rise_i,
  input  logic             ie_fall_i,
  input  logic             pend_clr_i,
  output logic             in_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             pend_o
);
  typedef logic [DEB_W-1:0] cnt_t;

  logic                   drv_oe;
  logic                   drv_a;
  logic                   pad_y;
  logic                   s_w;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  cnt_t                   cnt_q, cnt_d;
  logic                   in_q, in_d;
  logic                   pend_q, pend_d;
  tc_io_edge_t            edg_q, edg_d;

`ifdef TC_IO_OPEN_DRAIN_EN
  // Open-drain: pull low or release, never drive high
  assign drv_oe = od_i ? (oe_i & ~out_i) : oe_i;
  assign drv_a  = od_i ? 1'b0 : out_i;
`else
  assign drv_oe = oe_i;
  assign drv_a  = out_i;
`endif

  if (SCHMITT) begin : g_schmitt
    tc_io_tri_schmitt_pad u_pad (
      .a_i    (drv_a),
      .oe_i   (drv_oe),
      .y_o    (pad_y),
      .pad_io (pad_io)
    );
  end else begin : g_plain
    tc_io_tri_pad u_pad (
      .a_i    (drv_a),
      .oe_i   (drv_oe),
      .y_o    (pad_y),
      .pad_io (pad_io)
    );
  end

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pad_y};
    s_w    = sync_q[SYNC_STAGES-1];
    in_d   = in_q;
    cnt_d  = '0;
    if (!deb_en_i) begin
      in_d = s_w;
    end else if (s_w == in_q) begin
      cnt_d = '0;
    end else if (cnt_q >= deb_thr_i) begin
      in_d = s_w;
    end else begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end
    edg_d.rise = in_d & ~in_q;
    edg_d.fall = ~in_d & in_q;
    pend_d = (edg_q.rise & ie_rise_i)
           | (edg_q.fall & ie_fall_i)
           | (pend_q & ~pend_clr_i);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
      cnt_q  <= '0;
      in_q   <= 1'b0;
      edg_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      in_q   <= in_d;
      edg_q  <= edg_d;
      pend_q <= pend_d;
    end
  end

  assign in_o   = in_q;
  assign rise_o = edg_q.rise;
  assign fall_o = edg_q.fall;
  assign pend_o = pend_q;
endmodule

// File: rtl/tc_io_tri_pad.sv
// Behavioural model of the plain tristate pad cell.
module tc_io_tri_pad (
  input  logic a_i,
  input  logic oe_i,
  output logic y_o,
  inout  wire  pad_io
);
  assign pad_io = oe_i ? a_i : 1'bz;
  assign y_o    = pad_io;
endmodule

// File: rtl/tc_io_tri_schmitt_pad.sv
// Behavioural model of the schmitt-input tristate pad cell.
module tc_io_tri_schmitt_pad (
  input  logic a_i,
  input  logic oe_i,
  output logic y_o,
  inout  wire  pad_io
);
  assign pad_io = oe_i ? a_i : 1'bz;
  assign y_o    = pad_io;
endmodule

// File: rtl/tc_io_gpio_bank.sv
// Bank of NUM_PAD GPIO channels with a registered interrupt line.
// TC_IO_OPEN_DRAIN_EN enables per-channel open-drain output mode.
module tc_io_gpio_bank
  import tc_io_pkg::*;
#(
  parameter int                 NUM_PAD      = TC_IO_NUM_PAD_DEF,
  parameter int                 SYNC_STAGES  = TC_IO_SYNC_DEF,
  parameter int                 DEB_W        = TC_IO_DEB_W_DEF,
  parameter logic [NUM_PAD-1:0] SCHMITT_MASK = '0
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  inout  wire  [NUM_PAD-1:0] pad_io,
  tc_io_gpio_if.slave        bus
);
  logic [NUM_PAD-1:0] in_w;
  logic [NUM_PAD-1:0] rise_w;
  logic [NUM_PAD-1:0] fall_w;
  logic [NUM_PAD-1:0] pend_w;
  logic               irq_q, irq_d;

  for (genvar i = 0; i < NUM_PAD; i++) begin : g_chan
    tc_io_gpio_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_W       (DEB_W),
      .SCHMITT     (SCHMITT_MASK[i])
    ) u_chan (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .pad_io     (pad_io[i]),
      .out_i      (bus.out_i[i]),
      .oe_i       (bus.oe_i[i]),
`ifdef TC_IO_OPEN_DRAIN_EN
      .od_i       (bus.od_i[i]),
`endif
      .deb_en_i   (bus.deb_en_i[i]),
      .deb_thr_i  (bus.deb_thr_i),
      .ie_rise_i  (bus.ie_rise_i[i]),
      .ie_fall_i  (bus.ie_fall_i[i]),
      .pend_clr_i (bus.pend_clr_i[i]),
      .in_o       (in_w[i]),
      .rise_o     (rise_w[i]),
      .fall_o     (fall_w[i]),
      .pend_o     (pend_w[i])
    );
  end

  assign irq_d = |pend_w;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end

  assign bus.in_o   = in_w;
  assign bus.rise_o = rise_w;
  assign bus.fall_o = fall_w;
  assign bus.pend_o = pend_w;
  assign bus.irq_o  = irq_q;
endmodule
